// File: rtl/bm_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   BITS0  - default divisor / remainder width
//   BITS2  - default dividend / quotient width (also the iteration count)
//   CNT_W  - iteration counter width
//   state_t - controller states IDLE / BUSY / DONE
package bm_div_pkg;

  localparam int BITS0 = 9;
  localparam int BITS2 = 18;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bm_div_step.sv
// One restoring-division iteration (purely combinational).
//   rem      in   W_R  partial remainder
//   q        in   W_Q  dividend bits still to shift in / quotient bits retired so far
//   divisor  in   W_R  divisor
//   rem_next out  W_R  partial remainder after this iteration
//   q_next   out  W_Q  shifted quotient with the new bit in q_next[0]
module bm_div_step #(
  parameter int W_R = bm_div_pkg::BITS0,
  parameter int W_Q = bm_div_pkg::BITS2
) (
  input  logic [W_R-1:0] rem,
  input  logic [W_Q-1:0] q,
  input  logic [W_R-1:0] divisor,
  output logic [W_R-1:0] rem_next,
  output logic [W_Q-1:0] q_next
);
  import bm_div_pkg::*;

  // One extra bit so the shifted remainder can be compared against the divisor
  // without overflow.
  logic [W_R:0] shifted;

  always_comb begin
    shifted = {rem, q[W_Q-1]};
    if (shifted >= {1'b0, divisor}) begin
      // With a non-zero divisor the difference is always below the divisor, so
      // dropping the top bit is lossless. With a zero divisor the truncation is
      // what leaves the low dividend bits in the remainder.
      rem_next = W_R'(shifted - {1'b0, divisor});
      q_next   = {q[W_Q-2:0], 1'b1};
    end else begin
      rem_next = shifted[W_R-1:0];
      q_next   = {q[W_Q-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bm_seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      idle, will accept on in_valid
//   dividend   in   BITS2  unsigned dividend
//   divisor    in   BITS0  unsigned divisor
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result
//   quotient   out  BITS2  unsigned quotient
//   remainder  out  BITS0  unsigned remainder
//   div_zero   out  1      divisor was zero (only with BM_DIV_ZERO_FLAG_EN)
// Build option: define BM_DIV_ZERO_FLAG_EN to add div_zero and a one-cycle
// shortcut for a zero divisor.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | iterating, one quotient bit per clock
// DONE  | result presented, waiting for out_ready
module bm_seq_divider #(
  parameter int BITS0 = bm_div_pkg::BITS0,
  parameter int BITS2 = bm_div_pkg::BITS2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS2-1:0] dividend,
  input  logic [BITS0-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS2-1:0] quotient,
  output logic [BITS0-1:0] remainder
`ifdef BM_DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);
  import bm_div_pkg::*;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [BITS0-1:0] div_r, rem_r, rem_step;
  logic [BITS2-1:0] q_r, q_step;
  logic [BITS2-1:0] quotient_r;
  logic [BITS0-1:0] remainder_r;
  logic             accept, last_iter, zero_div;

  assign accept    = in_valid && (state == IDLE);
  assign last_iter = (state == BUSY) && (cnt == '0);

`ifdef BM_DIV_ZERO_FLAG_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  bm_div_step #(.W_R(BITS0), .W_Q(BITS2)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (div_r),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = zero_div ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Down-counter loaded with BITS2-1 on accept; the iteration taken while it
  // reads zero is the last one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      div_r       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      if (accept) begin
        div_r <= divisor;
        rem_r <= '0;
        q_r   <= dividend;
        cnt   <= CNT_W'(BITS2 - 1);
      end else if (state == BUSY) begin
        rem_r <= rem_step;
        q_r   <= q_step;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
      if (last_iter) begin
        quotient_r  <= q_step;
        remainder_r <= rem_step;
      end else if (accept && zero_div) begin
        // Same values the full iteration would produce for a zero divisor.
        quotient_r  <= '1;
        remainder_r <= dividend[BITS0-1:0];
      end
    end
  end

`ifdef BM_DIV_ZERO_FLAG_EN
  logic div_zero_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              div_zero_r <= 1'b0;
    else if (accept)                        div_zero_r <= zero_div;
    else if (state == DONE && out_ready)    div_zero_r <= 1'b0;
  end

  assign div_zero = div_zero_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_bm_seq_divider.sv
// Self-checking bench for bm_seq_divider (default parameters).
// Expected results come from a behavioural divide model pushed into a
// scoreboard at accept time and popped when the result is presented.
module tb_bm_seq_divider;

  localparam int B0 = 9;
  localparam int B2 = 18;
`ifdef BM_DIV_ZERO_FLAG_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = B2;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [B2-1:0] dividend;
  logic [B0-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [B2-1:0] quotient;
  logic [B0-1:0] remainder;
`ifdef BM_DIV_ZERO_FLAG_EN
  logic          div_zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [B2-1:0] q;
    logic [B0-1:0] r;
`ifdef BM_DIV_ZERO_FLAG_EN
    logic          dz;
`endif
  } exp_t;

  exp_t sb[$];

  bm_seq_divider dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef BM_DIV_ZERO_FLAG_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [B2-1:0] d, input logic [B0-1:0] s);
    exp_t e;
    if (s == '0) begin
      e.q = '1;
      e.r = d[B0-1:0];
    end else begin
      e.q = d / B2'(s);
      e.r = B0'(d % B2'(s));
    end
`ifdef BM_DIV_ZERO_FLAG_EN
    e.dz = (s == '0);
`endif
    return e;
  endfunction

  // Present operands, wait (bounded) for acceptance, push the expected result.
  task automatic start_op(input logic [B2-1:0] d, input logic [B0-1:0] s);
    int n;
    @(negedge clock);
    dividend = d;
    divisor  = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    sb.push_back(model(d, s));
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid is seen.
  task automatic wait_valid(input int exp_lat, input string nm);
    int n;
    @(negedge clock);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=%0d out_valid=%0b", nm, n, exp_lat, out_valid);
    end
  endtask

  // Optionally stall in DONE, then compare against the scoreboard and handshake.
  task automatic finish_op(input int hold, input string nm);
    exp_t e;
    logic [B2-1:0] q0;
    logic [B0-1:0] r0;
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q0 || remainder !== r0) begin
        errors++;
        $display("FAIL %s_hold cyc=%0d out_valid=%0b in_ready=%0b q=%0d r=%0d required 1 0 %0d %0d",
                 nm, i, out_valid, in_ready, quotient, remainder, q0, r0);
      end
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard_empty got=0 required=1", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (quotient !== e.q) begin
        errors++;
        $display("FAIL %s_quotient got=%0d required=%0d", nm, quotient, e.q);
      end
      checks++;
      if (remainder !== e.r) begin
        errors++;
        $display("FAIL %s_remainder got=%0d required=%0d", nm, remainder, e.r);
      end
`ifdef BM_DIV_ZERO_FLAG_EN
      checks++;
      if (div_zero !== e.dz) begin
        errors++;
        $display("FAIL %s_div_zero got=%0b required=%0b", nm, div_zero, e.dz);
      end
`endif
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%0b out_valid=%0b q=%0d r=%0d required 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    start_op(18'd1000, 9'd7);
    wait_valid(B2, "div_1000_7");
    finish_op(0, "div_1000_7");
    start_op(18'd262143, 9'd511);
    wait_valid(B2, "div_max_511");
    finish_op(0, "div_max_511");
    start_op(18'd5, 9'd9);
    wait_valid(B2, "div_5_9");
    finish_op(0, "div_5_9");
  endtask

  task automatic test_div_zero();
    start_op(18'd300, 9'd0);
    wait_valid(ZLAT, "div_zero");
    finish_op(0, "div_zero");
  endtask

  task automatic test_hold();
    start_op(18'd1000, 9'd7);
    // New operands during BUSY/DONE must neither be sampled nor accepted.
    dividend = 18'd50;
    divisor  = 9'd5;
    in_valid = 1'b1;
    wait_valid(B2, "hold");
    finish_op(5, "hold");
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 18'd142 || remainder !== 9'd6) begin
      errors++;
      $display("FAIL hold_post_handshake in_ready=%0b out_valid=%0b q=%0d r=%0d required 1 0 142 6",
               in_ready, out_valid, quotient, remainder);
    end
    sb.push_back(model(18'd50, 9'd5));
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_valid(B2, "hold_next");
    finish_op(0, "hold_next");
  endtask

  task automatic test_back_to_back();
    logic [B2-1:0] dv[2];
    logic [B0-1:0] ds[2];
    int acc_cyc[$];
    int idx;
    int done_cnt;
    exp_t e;
    dv[0] = 18'd100; ds[0] = 9'd3;
    dv[1] = 18'd255; ds[1] = 9'd16;
    idx = 0;
    done_cnt = 0;
    @(negedge clock);
    out_ready = 1'b1;
    dividend  = dv[0];
    divisor   = ds[0];
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 120 && done_cnt < 2; cyc++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b2b_spurious_valid cyc=%0d got=1 required=0", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_result%0d got=%0d r%0d required=%0d r%0d",
                     done_cnt, quotient, remainder, e.q, e.r);
          end
        end
        done_cnt++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(dividend, divisor));
        acc_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clock);
      #1;
      if (idx == 1) begin
        dividend = dv[1];
        divisor  = ds[1];
      end else if (idx >= 2) begin
        in_valid = 1'b0;
      end
      @(negedge clock);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=2", done_cnt);
    end
    checks++;
    if (acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_accepts got=%0d required=2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != B2 + 2) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d required=%0d", acc_cyc[1] - acc_cyc[0], B2 + 2);
    end
    sb.delete();
  endtask

  task automatic test_reset_abort();
    start_op(18'd1000, 9'd7);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0) begin
      errors++;
      $display("FAIL abort_immediate out_valid=%0b in_ready=%0b q=%0d required 0 1 0",
               out_valid, in_ready, quotient);
    end
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (B2 + 2) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result out_valid=%0b required=0", out_valid);
    end
    start_op(18'd50, 9'd5);
    wait_valid(B2, "after_abort");
    finish_op(0, "after_abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
